// File: rtl/tros_measure_sequencer.sv
// Sequencer for one ring-oscillator measurement round: clear, gate, latch, then frame each enabled channel.
// Latency: start sampled on edge N gives CLEAR from cycle N+1; all outputs registered.
// Backpressure: none; each send is paced by a fixed frame-shift time. Optional TROS_SEQ_ROUND_CNT_EN adds round_count.
module tros_measure_sequencer #(
    parameter int GATE_WIDTH = 16,
    parameter int CTR_LENGTH = 20,
    parameter int SYNC_DEPTH = 3,
    parameter int RESET_HOLD = 4,
    parameter int LATCH_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [GATE_WIDTH-1:0] gate_cycles,
    input  logic [2:0]            channel_mask,
    output logic                  ctr_reset,
    output logic                  latch_counter,
    output logic                  send_counter,
    output logic [1:0]            counter_select,
    output logic                  busy,
    output logic                  round_done
`ifdef TROS_SEQ_ROUND_CNT_EN
    ,
    output logic [7:0]            round_count
`endif
);

    localparam int SHIFT_LEN = SYNC_DEPTH + CTR_LENGTH + 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CW = max2(GATE_WIDTH, max2($clog2(SHIFT_LEN + 1),
                        max2($clog2(RESET_HOLD + 1), $clog2(LATCH_HOLD + 1))));

    localparam logic [CW-1:0] RESET_LD = CW'(RESET_HOLD - 1);
    localparam logic [CW-1:0] LATCH_LD = CW'(LATCH_HOLD - 1);
    localparam logic [CW-1:0] SHIFT_LD = CW'(SHIFT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GATE, S_LATCH, S_SEND, S_SHIFT, S_DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [GATE_WIDTH-1:0] gate_q;
    logic [2:0]            mask_q;
    logic [2:0]            first_ch;
    logic [2:0]            next_ch;
    logic [CW-1:0]         gate_load;

    // Returns {found, index} of the lowest enabled channel at or above 'from'.
    function automatic logic [2:0] pick(input logic [2:0] mask, input int from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (mask[i] && (i >= from)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign first_ch  = pick(mask_q, 0);
    assign next_ch   = pick(mask_q, int'(counter_select) + 1);
    // A zero gate length still spends one cycle in GATE.
    assign gate_load = (gate_q == '0) ? '0 : (CW'(gate_q) - CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            gate_q         <= '0;
            mask_q         <= '0;
            ctr_reset      <= 1'b0;
            latch_counter  <= 1'b0;
            send_counter   <= 1'b0;
            counter_select <= 2'b11;
            busy           <= 1'b0;
            round_done     <= 1'b0;
`ifdef TROS_SEQ_ROUND_CNT_EN
            round_count    <= 8'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_CLEAR;
                        cnt       <= RESET_LD;
                        gate_q    <= gate_cycles;
                        mask_q    <= channel_mask;
                        ctr_reset <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (cnt == '0) begin
                        state     <= S_GATE;
                        cnt       <= gate_load;
                        ctr_reset <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GATE: begin
                    if (cnt == '0) begin
                        state         <= S_LATCH;
                        cnt           <= LATCH_LD;
                        latch_counter <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_LATCH: begin
                    if (cnt == '0) begin
                        latch_counter <= 1'b0;
                        if (first_ch[2]) begin
                            state          <= S_SEND;
                            send_counter   <= 1'b1;
                            counter_select <= first_ch[1:0];
                        end else begin
                            state      <= S_DONE;
                            round_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SEND: begin
                    state        <= S_SHIFT;
                    cnt          <= SHIFT_LD;
                    send_counter <= 1'b0;
                end
                S_SHIFT: begin
                    // Hold the channel until its whole frame has left the consumer.
                    if (cnt == '0) begin
                        if (next_ch[2]) begin
                            state          <= S_SEND;
                            send_counter   <= 1'b1;
                            counter_select <= next_ch[1:0];
                        end else begin
                            state          <= S_DONE;
                            round_done     <= 1'b1;
                            counter_select <= 2'b11;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    round_done <= 1'b0;
`ifdef TROS_SEQ_ROUND_CNT_EN
                    round_count <= round_count + 8'd1;
`endif
                    if (continuous) begin
                        state     <= S_CLEAR;
                        cnt       <= RESET_LD;
                        gate_q    <= gate_cycles;
                        mask_q    <= channel_mask;
                        ctr_reset <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    ctr_reset      <= 1'b0;
                    latch_counter  <= 1'b0;
                    send_counter   <= 1'b0;
                    counter_select <= 2'b11;
                    busy           <= 1'b0;
                    round_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tros_measure_sequencer.sv
// Bench for tros_measure_sequencer: expected per-cycle output trace built from round rules.
module tb_tros_measure_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] gate_cycles = 16'd0;
    logic [2:0]  channel_mask = 3'd0;
    logic        ctr_reset, latch_counter, send_counter, busy, round_done;
    logic [1:0]  counter_select;
`ifdef TROS_SEQ_ROUND_CNT_EN
    logic [7:0]  round_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // {ctr_reset, latch_counter, send_counter, counter_select, busy, round_done}
    logic [6:0] exp_q[$];
    logic [6:0] obs;
    assign obs = {ctr_reset, latch_counter, send_counter, counter_select, busy, round_done};

    localparam logic [6:0] V_IDLE = 7'b000_11_0_0;

    tros_measure_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .gate_cycles(gate_cycles), .channel_mask(channel_mask),
        .ctr_reset(ctr_reset), .latch_counter(latch_counter),
        .send_counter(send_counter), .counter_select(counter_select),
        .busy(busy), .round_done(round_done)
`ifdef TROS_SEQ_ROUND_CNT_EN
        , .round_count(round_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check7(input string tag, input int idx, input logic [6:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s idx=%0d got=%b exp=%b", tag, idx, obs, exp);
        end
    endtask

    // One full round as seen on the outputs, from the first CLEAR cycle to DONE.
    task automatic push_round(input int g, input logic [2:0] m);
        int shift_len = 3 + 20 + 4;
        repeat (4) exp_q.push_back(7'b100_11_1_0);
        repeat ((g == 0) ? 1 : g) exp_q.push_back(7'b000_11_1_0);
        repeat (4) exp_q.push_back(7'b010_11_1_0);
        for (int ch = 0; ch < 3; ch++) begin
            if (m[ch]) begin
                exp_q.push_back({3'b001, 2'(ch), 2'b10});
                repeat (shift_len) exp_q.push_back({3'b000, 2'(ch), 2'b10});
            end
        end
        exp_q.push_back(7'b000_11_1_1);
    endtask

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(V_IDLE);
    endtask

    task automatic run_expect(input string tag, input int start_off, input int chg_at,
                              input logic [15:0] gate_val, input logic [2:0] mask_val,
                              input int cont_at, input int limit);
        int idx = 0;
        while (exp_q.size() > 0 && idx < limit) begin
            @(negedge clk);
            if (idx == start_off) start = 1'b0;
            if (idx == chg_at) begin
                gate_cycles  = gate_val;
                channel_mask = mask_val;
            end
            if (idx == cont_at) continuous = 1'b0;
            check7(tag, idx, exp_q.pop_front());
            idx++;
        end
        exp_q.delete();
    endtask

    initial begin
        int g, L, ci;
        logic [2:0] m;

        #2 rst_n = 1'b0;
        #1 check7("reset", 0, V_IDLE);
`ifdef TROS_SEQ_ROUND_CNT_EN
        n_checks++;
        assert (round_count === 8'd0) else begin
            n_fail++;
            $error("FAIL round_count_reset got=%0d exp=0", round_count);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check7("idle_after_reset", 0, V_IDLE);

        // Single channel 0, gate 10: 47 busy cycles.
        start = 1'b1; gate_cycles = 16'd10; channel_mask = 3'b001;
        push_round(10, 3'b001); push_idle(2);
        run_expect("mask001", 0, -1, 16'd0, 3'd0, -1, 100000);

        // Channels 0 and 2, sends 28 cycles apart.
        start = 1'b1; gate_cycles = 16'd5; channel_mask = 3'b101;
        push_round(5, 3'b101); push_idle(2);
        run_expect("mask101", 0, -1, 16'd0, 3'd0, -1, 100000);

        // Empty mask and zero gate: 10 busy cycles.
        start = 1'b1; gate_cycles = 16'd0; channel_mask = 3'b000;
        push_round(0, 3'b000); push_idle(2);
        run_expect("mask000", 0, -1, 16'd0, 3'd0, -1, 100000);

        // Continuous: gate change in round 1 applies to round 2; stop during round 2 GATE.
        start = 1'b1; continuous = 1'b1; gate_cycles = 16'd3; channel_mask = 3'b010;
        push_round(3, 3'b010);
        L = exp_q.size();
        push_round(7, 3'b010); push_idle(3);
        run_expect("continuous", 0, 2, 16'd7, 3'b010, L + 5, 100000);

        // Start held high: ignored while busy, restarts after one IDLE cycle.
        g = $urandom_range(0, 8); m = 3'($urandom_range(0, 7));
        start = 1'b1; gate_cycles = 16'(g); channel_mask = m;
        push_round(g, m);
        L = exp_q.size();
        push_idle(1); push_round(g, m); push_idle(2);
        run_expect("start_held", L + 1, -1, 16'd0, 3'd0, -1, 100000);

        // Random rounds with inputs disturbed mid-round.
        for (int r = 0; r < 6; r++) begin
            g = $urandom_range(0, 12); m = 3'($urandom_range(0, 7));
            start = 1'b1; gate_cycles = 16'(g); channel_mask = m;
            push_round(g, m);
            L = exp_q.size();
            push_idle(2);
            ci = $urandom_range(1, L - 1);
            run_expect("random", 0, ci, 16'($urandom_range(0, 40)),
                       3'($urandom_range(0, 7)), -1, 100000);
        end

        // Reset asserted during SHIFT.
        start = 1'b1; gate_cycles = 16'd4; channel_mask = 3'b011;
        push_round(4, 3'b011);
        run_expect("pre_reset", 0, -1, 16'd0, 3'd0, -1, 18);
        #2 rst_n = 1'b0;
        #1 check7("reset_in_shift", 0, V_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(4);
        run_expect("idle_after_rst", 0, -1, 16'd0, 3'd0, -1, 100000);

`ifdef TROS_SEQ_ROUND_CNT_EN
        // 257 continuous empty rounds wrap the counter to 1.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1; continuous = 1'b1; gate_cycles = 16'd0; channel_mask = 3'b000;
        for (int r = 0; r < 257; r++) push_round(0, 3'b000);
        L = exp_q.size();
        push_idle(2);
        run_expect("round_cnt", 0, -1, 16'd0, 3'd0, L - 5, 100000);
        n_checks++;
        assert (round_count === 8'd1) else begin
            n_fail++;
            $error("FAIL round_count_wrap got=%0d exp=1", round_count);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
